// File: rtl/button_event.sv
// Classifies a debounced button level into short-press, long-press and
// auto-repeat single-cycle pulses for the downstream control FSM.
module button_event #(
   parameter int unsigned CLK_FREQ  = 25_000_000,
   parameter int unsigned LONG_MS   = 500,
   parameter int unsigned REPEAT_MS = 100,
   parameter bit          REPEAT_EN = 1'b1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       signal_i,
   output logic       held_o,
   output logic       press_o,
   output logic       long_o,
   output logic       repeat_o,
   output logic [1:0] state_o
);

   localparam int unsigned LONG_TICKS   = CLK_FREQ / 1000 * LONG_MS;
   localparam int unsigned REPEAT_TICKS = CLK_FREQ / 1000 * REPEAT_MS;
   localparam int unsigned MAX_TICKS    = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
   localparam int          CNT_W        = $clog2(MAX_TICKS + 1);

   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);

   if (LONG_TICKS < 2) begin : g_bad_long
      $error("button_event: LONG_TICKS must be at least 2");
   end
   if (REPEAT_TICKS < 1) begin : g_bad_repeat
      $error("button_event: REPEAT_TICKS must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      LONG    = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sig_q;

   assign state_o = state;

   // sig_q resets to 1 so a button already held out of reset must be
   // released and pressed again before any event is produced.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= IDLE;
         cnt      <= '0;
         sig_q    <= 1'b1;
         held_o   <= 1'b0;
         press_o  <= 1'b0;
         long_o   <= 1'b0;
         repeat_o <= 1'b0;
      end else begin
         sig_q    <= signal_i;
         press_o  <= 1'b0;
         long_o   <= 1'b0;
         repeat_o <= 1'b0;
         case (state)
            IDLE: begin
               if (signal_i && !sig_q) begin
                  state  <= PRESSED;
                  cnt    <= '0;
                  held_o <= 1'b1;
               end
            end
            PRESSED: begin
               // A release on the terminal-count edge still counts as short.
               if (!signal_i) begin
                  state   <= IDLE;
                  cnt     <= '0;
                  held_o  <= 1'b0;
                  press_o <= 1'b1;
               end else if (cnt == LONG_LAST) begin
                  state  <= LONG;
                  cnt    <= '0;
                  long_o <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LONG: begin
               if (!signal_i) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  held_o <= 1'b0;
               end else if (REPEAT_EN) begin
                  if (cnt == REPEAT_LAST) begin
                     cnt      <= '0;
                     repeat_o <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else begin
                  cnt <= '0;
               end
            end
            default: begin
               state  <= IDLE;
               cnt    <= '0;
               held_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench: two instances (repeat enabled / disabled) share one
// stimulus stream; expected events are time-stamped by edge index.
module tb_button_event;

   localparam int LONG = 500;
   localparam int REP  = 100;
   localparam int W    = 24;

   localparam logic [2:0] EV_PRESS  = 3'b100;
   localparam logic [2:0] EV_LONG   = 3'b010;
   localparam logic [2:0] EV_REPEAT = 3'b001;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       signal;
   logic       held0, press0, long0, rep0;
   logic       held1, press1, long1, rep1;
   logic [1:0] state0, state1;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   logic [W-1:0] exp0_q[$];
   logic [W-1:0] exp1_q[$];

   button_event #(
      .CLK_FREQ(10000), .LONG_MS(50), .REPEAT_MS(10), .REPEAT_EN(1'b1)
   ) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .signal_i(signal), .held_o(held0),
      .press_o(press0), .long_o(long0), .repeat_o(rep0), .state_o(state0)
   );

   button_event #(
      .CLK_FREQ(10000), .LONG_MS(50), .REPEAT_MS(10), .REPEAT_EN(1'b0)
   ) dut1 (
      .clk_i(clk), .rst_ni(rst_n), .signal_i(signal), .held_o(held1),
      .press_o(press1), .long_o(long1), .repeat_o(rep1), .state_o(state1)
   );

   // clock / reset
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] ev(input logic [2:0] t, input int c);
      logic [31:0] cv;
      cv = c;
      return {t, cv[20:0]};
   endfunction

   // Monitors: every cycle a pulse is seen, it must match the queue head.
   always @(negedge clk) begin
      if (press0 || long0 || rep0) begin
         if (exp0_q.size() == 0) check("unexpected0", {8'd0, press0, long0, rep0, cyc[20:0]}, 32'd0);
         else check("event0", {8'd0, press0, long0, rep0, cyc[20:0]}, {8'd0, exp0_q.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (press1 || long1 || rep1) begin
         if (exp1_q.size() == 0) check("unexpected1", {8'd0, press1, long1, rep1, cyc[20:0]}, 32'd0);
         else check("event1", {8'd0, press1, long1, rep1, cyc[20:0]}, {8'd0, exp1_q.pop_front()});
      end
   end

   task automatic drain(input string tag);
      check({tag, "_drain0"}, exp0_q.size(), 0);
      check({tag, "_drain1"}, exp1_q.size(), 0);
   endtask

   // Driver: hold the button for 'hold' sampled edges, then release.
   task automatic press(input string tag, input int hold);
      int k;
      @(negedge clk);
      signal = 1'b1;
      k = cyc + 1;
      if (hold <= LONG) begin
         exp0_q.push_back(ev(EV_PRESS, k + hold));
         exp1_q.push_back(ev(EV_PRESS, k + hold));
      end else begin
         exp0_q.push_back(ev(EV_LONG, k + LONG));
         exp1_q.push_back(ev(EV_LONG, k + LONG));
         for (int e = k + LONG + REP; e < k + hold; e += REP)
            exp0_q.push_back(ev(EV_REPEAT, e));
      end
      @(negedge clk);
      check({tag, "_held_first"}, held0, 1);
      repeat (hold - 1) @(negedge clk);
      check({tag, "_held_last"}, {held1, held0}, 2'b11);
      signal = 1'b0;
      @(negedge clk);
      check({tag, "_held_off"}, {held1, held0}, 2'b00);
      repeat (10) @(negedge clk);
      drain(tag);
   endtask

   initial begin
      int k;
      rst_n  = 1'b0;
      signal = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_outs0", {held0, press0, long0, rep0}, 4'b0000);
      check("rst_outs1", {held1, press1, long1, rep1}, 4'b0000);
      check("rst_state0", state0, 2'd0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      press("short", 200);
      press("long750", 750);
      press("edge500", 500);
      press("edge501", 501);
      press("long800", 800);

      // reset while held: no events until a fresh low->high edge
      signal = 1'b1;
      rst_n  = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (1000) @(negedge clk);
      check("rsthold_held", {held1, held0}, 2'b00);
      signal = 1'b0;
      repeat (5) @(negedge clk);
      drain("rsthold");
      press("after_rst", 200);

      // one-cycle reset 300 edges into a hold drops the pending long event
      @(negedge clk);
      signal = 1'b1;
      k = cyc + 1;
      repeat (300) @(negedge clk);
      check("mid_k", cyc, k + 299);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_outs0", {held0, press0, long0, rep0}, 4'b0000);
      check("midrst_outs1", {held1, press1, long1, rep1}, 4'b0000);
      rst_n = 1'b1;
      repeat (500) @(negedge clk);
      check("midrst_held", held0, 0);
      signal = 1'b0;
      repeat (10) @(negedge clk);
      drain("midrst");

      for (int i = 0; i < 4; i++) begin
         int h;
         h = $urandom_range(2, 900);
         press($sformatf("rnd%0d_h%0d", i, h), h);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
